// File: rtl/prefetcher_pkg.sv
// prefetcher_pkg: shared error codes and burst tracking entry for the read burst tracker.
package prefetcher_pkg;
    localparam int TID_W = 8;
    localparam int LEN_W = 8;
    localparam logic [2:0] ERR_NONE            = 3'd0;
    localparam logic [2:0] ERR_UNEXPECTED_BEAT = 3'd1;
    localparam logic [2:0] ERR_ID_MISMATCH     = 3'd2;
    localparam logic [2:0] ERR_EARLY_LAST      = 3'd3;
    localparam logic [2:0] ERR_MISSING_LAST    = 3'd4;
    typedef struct packed {
        logic [TID_W-1:0] id;
        logic [LEN_W-1:0] len;
    } burst_entry_t;
endpackage

// File: rtl/burst_track_fifo.sv
// burst_track_fifo: in-order FIFO of accepted AR bursts, depth 2^LOG_DEPTH.
module burst_track_fifo
    import prefetcher_pkg::*;
#(
    parameter int LOG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  burst_entry_t         push_data,
    input  logic                 pop,
    output burst_entry_t         head,
    output logic [LOG_DEPTH:0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CW = LOG_DEPTH + 1;
    burst_entry_t mem_q [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH:0] count_q, count_d;
    logic do_push, do_pop;
    always_comb begin
        full     = count_q == CW'(DEPTH);
        empty    = count_q == '0;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        head     = mem_q[rd_ptr_q];
        count    = count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push && !rst) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/axi_rd_burst_tracker.sv
// axi_rd_burst_tracker: AXI read pass-through that tracks bursts in order, checks R beats
// against the oldest outstanding AR, throttles at FIFO depth and freezes on a sticky error.
module axi_rd_burst_tracker
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int LOG_DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [ADDR_BITS-1:0]       s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic [TID_WIDTH-1:0]       s_ar_id,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic [TID_WIDTH-1:0]       m_r_id,
    input  logic                       m_r_last,
    output logic                       s_r_valid,
    input  logic                       s_r_ready,
    output logic [DATA_WIDTH-1:0]      s_r_data,
    output logic [TID_WIDTH-1:0]       s_r_id,
    output logic                       s_r_last,
    output logic [LOG_DEPTH:0]         outstanding,
    output logic [BURST_LEN_WIDTH-1:0] beatCnt,
    output logic [2:0]                 errorCode
);
    logic [BURST_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [2:0] error_code_q, error_code_d, viol;
    logic err, full, empty, beat_ok, ar_hs, r_hs;
    burst_entry_t head, push_data;

    assign m_ar_addr = s_ar_addr;
    assign m_ar_len  = s_ar_len;
    assign m_ar_id   = s_ar_id;
    assign s_r_data  = m_r_data;
    assign s_r_id    = m_r_id;
    assign s_r_last  = m_r_last;

    burst_track_fifo #(.LOG_DEPTH(LOG_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ar_hs),
        .push_data (push_data),
        .pop       (r_hs & m_r_last),
        .head      (head),
        .count     (outstanding),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        err        = error_code_q != ERR_NONE;
        push_data  = '{id: TID_W'(s_ar_id), len: LEN_W'(s_ar_len)};
        beat_ok    = ~empty & (m_r_id == head.id) & (m_r_last == (beat_cnt_q == head.len));
        m_ar_valid = s_ar_valid & ~full & ~err;
        s_ar_ready = m_ar_ready & ~full & ~err;
        s_r_valid  = m_r_valid & beat_ok & ~err;
        m_r_ready  = s_r_ready & beat_ok & ~err;
        ar_hs      = s_ar_valid & s_ar_ready;
        r_hs       = m_r_valid & m_r_ready;
        // last clears the count, so a len of all-ones never wraps
        beat_cnt_d = r_hs ? (m_r_last ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;
        viol = empty                                   ? ERR_UNEXPECTED_BEAT :
               (m_r_id != head.id)                     ? ERR_ID_MISMATCH     :
               (m_r_last & (beat_cnt_q < head.len))    ? ERR_EARLY_LAST      :
               (~m_r_last & (beat_cnt_q == head.len))  ? ERR_MISSING_LAST    : ERR_NONE;
        error_code_d = (m_r_valid & ~err) ? viol : error_code_q;
        beatCnt      = beat_cnt_q;
        errorCode    = error_code_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q   <= '0;
            error_code_q <= ERR_NONE;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            error_code_q <= error_code_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_burst_tracker.sv
// tb_axi_rd_burst_tracker: directed plan scenarios plus randomized phases, all checked every
// cycle against a queue-based model of outstanding bursts.
module tb_axi_rd_burst_tracker;
    logic clk = 0, rst;
    logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
    logic [15:0] s_ar_addr, m_ar_addr;
    logic [7:0] s_ar_len, m_ar_len, s_ar_id, m_ar_id;
    logic m_r_valid, m_r_ready, m_r_last, s_r_valid, s_r_ready, s_r_last;
    logic [7:0] m_r_data, m_r_id, s_r_data, s_r_id;
    logic [2:0] outstanding;
    logic [7:0] beatCnt;
    logic [2:0] errorCode;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    axi_rd_burst_tracker dut (
        .clk(clk), .rst(rst),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
        .m_r_id(m_r_id), .m_r_last(m_r_last),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
        .s_r_id(s_r_id), .s_r_last(s_r_last),
        .outstanding(outstanding), .beatCnt(beatCnt), .errorCode(errorCode)
    );

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Model: list of outstanding bursts, beats taken of the oldest, sticky error.
    logic [7:0] q_id[$], q_len[$];
    int mcnt = 0, merr = 0;

    function automatic int violation();
        if (q_id.size() == 0) return 1;
        if (m_r_id != q_id[0]) return 2;
        if (m_r_last && mcnt < int'(q_len[0])) return 3;
        if (!m_r_last && mcnt == int'(q_len[0])) return 4;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q_id.delete(); q_len.delete(); mcnt = 0; merr = 0;
        end else begin
            automatic int v = violation();
            automatic bit e = merr != 0;
            automatic bit ar = s_ar_valid && m_ar_ready && q_id.size() < 4 && !e;
            automatic bit r = m_r_valid && s_r_ready && !e && v == 0;
            if (r) begin
                if (m_r_last) begin
                    void'(q_id.pop_front()); void'(q_len.pop_front()); mcnt = 0;
                end else mcnt++;
            end
            if (ar) begin q_id.push_back(s_ar_id); q_len.push_back(s_ar_len); end
            if (m_r_valid && !e && v != 0) merr = v;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            automatic bit e = merr != 0;
            automatic bit fl = q_id.size() == 4;
            automatic bit ok = violation() == 0;
            check("m_ar_valid", 32'(m_ar_valid), 32'(s_ar_valid && !fl && !e));
            check("s_ar_ready", 32'(s_ar_ready), 32'(m_ar_ready && !fl && !e));
            check("s_r_valid", 32'(s_r_valid), 32'(m_r_valid && ok && !e));
            check("m_r_ready", 32'(m_r_ready), 32'(s_r_ready && ok && !e));
            check("outstanding", 32'(outstanding), 32'(q_id.size()));
            check("beatCnt", 32'(beatCnt), 32'(mcnt));
            check("errorCode", 32'(errorCode), 32'(merr));
            check("ar_pass", {m_ar_addr, m_ar_len, m_ar_id}, {s_ar_addr, s_ar_len, s_ar_id});
            check("r_pass", {15'd0, s_r_data, s_r_id, s_r_last}, {15'd0, m_r_data, m_r_id, m_r_last});
        end
    end

    task automatic nxt(); @(posedge clk); #1; endtask

    task automatic idle();
        s_ar_valid = 0; s_ar_addr = 0; s_ar_len = 0; s_ar_id = 0; m_ar_ready = 0;
        m_r_valid = 0; m_r_data = 0; m_r_id = 0; m_r_last = 0; s_r_ready = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; nxt(); nxt(); rst = 0;
    endtask

    task automatic send_ar(input logic [7:0] len, input logic [7:0] id);
        s_ar_valid = 1; m_ar_ready = 1; s_ar_addr = 16'h0eef; s_ar_len = len; s_ar_id = id;
        nxt(); s_ar_valid = 0; m_ar_ready = 0;
    endtask

    task automatic beat(input logic [7:0] id, input logic last);
        m_r_valid = 1; s_r_ready = 1; m_r_id = id; m_r_last = last; m_r_data = 8'($urandom);
    endtask

    task automatic rand_cycle(input int inj);
        s_ar_valid = 1'($urandom); s_ar_addr = 16'($urandom);
        s_ar_len = ($urandom % 32 == 0) ? 8'hff : 8'($urandom_range(0, 3));
        s_ar_id = 8'($urandom_range(0, 7)); m_ar_ready = ($urandom % 4) != 0;
        s_r_ready = ($urandom % 4) != 0; m_r_data = 8'($urandom);
        if (q_id.size() != 0) begin
            m_r_valid = 1'($urandom); m_r_id = q_id[0]; m_r_last = (mcnt == int'(q_len[0]));
        end else begin
            m_r_valid = 0; m_r_id = 8'($urandom); m_r_last = 1'($urandom);
        end
        if (int'($urandom_range(0, 999)) < inj) begin
            m_r_valid = 1;
            case ($urandom % 3)
                0: m_r_id = m_r_id ^ 8'h01;
                1: m_r_last = ~m_r_last;
                default: ;
            endcase
        end
        nxt();
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_errorCode", 32'(errorCode), 0);
        check("rst_s_ar_ready", 32'(s_ar_ready), 0);
        check("rst_m_r_ready", 32'(m_r_ready), 0);
        nxt();

        // normal burst
        send_ar(8'd5, 8'd5);
        @(negedge clk); check("nb_outstanding1", 32'(outstanding), 1); nxt();
        for (int b = 0; b < 6; b++) begin
            beat(8'd5, b == 5);
            @(negedge clk);
            check("nb_s_r_valid", 32'(s_r_valid), 1);
            check("nb_s_r_last", 32'(s_r_last), 32'(b == 5));
            nxt();
        end
        idle();
        @(negedge clk);
        check("nb_outstanding0", 32'(outstanding), 0);
        check("nb_errorCode", 32'(errorCode), 0);
        nxt();

        // full throttle
        do_reset();
        for (int i = 0; i < 4; i++) send_ar(8'd0, 8'd5);
        s_ar_valid = 1; m_ar_ready = 1;
        @(negedge clk);
        check("ft_outstanding4", 32'(outstanding), 4);
        check("ft_s_ar_ready", 32'(s_ar_ready), 0);
        check("ft_m_ar_valid", 32'(m_ar_valid), 0);
        nxt();
        beat(8'd5, 1);
        @(negedge clk); check("ft_still_full", 32'(s_ar_ready), 0); nxt();
        m_r_valid = 0;
        @(negedge clk); check("ft_ready_after_pop", 32'(s_ar_ready), 1); nxt();
        idle();
        @(negedge clk); check("ft_refilled", 32'(outstanding), 4); nxt();

        // early last on beat index 3
        do_reset();
        send_ar(8'd5, 8'd5);
        for (int b = 0; b < 3; b++) begin beat(8'd5, 0); nxt(); end
        beat(8'd5, 1);
        @(negedge clk); check("el_not_forwarded", 32'(s_r_valid), 0); nxt();
        beat(8'd5, 0); s_ar_valid = 1; m_ar_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("el_errorCode", 32'(errorCode), 3);
            check("el_s_ar_ready", 32'(s_ar_ready), 0);
            check("el_m_r_ready", 32'(m_r_ready), 0);
            nxt();
        end

        // id mismatch
        do_reset();
        send_ar(8'd0, 8'd5);
        beat(8'd6, 1);
        @(negedge clk); check("id_s_r_valid", 32'(s_r_valid), 0); nxt();
        beat(8'd5, 1);
        @(negedge clk);
        check("id_errorCode", 32'(errorCode), 2);
        check("id_s_r_valid_frozen", 32'(s_r_valid), 0);
        nxt();

        // unexpected beat
        do_reset();
        beat(8'd1, 1);
        @(negedge clk); check("ub_m_r_ready", 32'(m_r_ready), 0); nxt();
        idle();
        @(negedge clk); check("ub_errorCode", 32'(errorCode), 1); nxt();

        // reset mid-burst
        do_reset();
        send_ar(8'd5, 8'd5);
        for (int b = 0; b < 2; b++) begin beat(8'd5, 0); nxt(); end
        idle(); rst = 1; nxt(); rst = 0;
        @(negedge clk);
        check("rm_outstanding", 32'(outstanding), 0);
        check("rm_beatCnt", 32'(beatCnt), 0);
        check("rm_errorCode", 32'(errorCode), 0);
        nxt();
        send_ar(8'd1, 8'd3);
        beat(8'd3, 0); nxt();
        beat(8'd3, 1);
        @(negedge clk); check("rm_last_fwd", 32'(s_r_valid & s_r_last), 1); nxt();
        idle();
        @(negedge clk);
        check("rm_done_outstanding", 32'(outstanding), 0);
        check("rm_done_errorCode", 32'(errorCode), 0);
        nxt();

        // randomized phases, some with error injection
        for (int p = 0; p < 8; p++) begin
            do_reset();
            for (int c = 0; c < 600; c++) rand_cycle(p < 4 ? 0 : 3);
        end
        idle();
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
